// File: rtl/rr_sched4_if.sv
// Handshake bundle between the four clients and the round-robin scheduler.
// The scheduler connects through the slave modport; the client side
// (or a bench acting for it) uses master.
interface rr_sched4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       tmo;

  modport master (
    output req, done,
    input  gnt, gnt_id, busy, tmo
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, busy, tmo
  );
endinterface

// File: rtl/rr_sched4.sv
// Round-robin scheduler: four requesters share one resource. A one-hot
// priority pointer rotates past each owner on release; a grant is held until
// done, the owner's request drops, or (optionally) a hold timeout.
// Optional feature macro: RR_TIMEOUT_EN enables the MAX_HOLD timeout and tmo.
module rr_sched4 #(
  parameter int MAX_HOLD = 15
) (
  input  logic        clk,
  input  logic        rst,
  rr_sched4_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic [7:0] hold_q, hold_d;

  logic [1:0] win;
  logic       owner_req;
  logic       hit;

  // First set request bit at or after the one-hot pointer, wrapping 3->0.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [3:0] p);
    logic [1:0] base;
    logic [1:0] idx;
    logic       found;
    pick  = 2'd0;
    found = 1'b0;
    unique case (p)
      4'b0010: base = 2'd1;
      4'b0100: base = 2'd2;
      4'b1000: base = 2'd3;
      default: base = 2'd0;
    endcase
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

`ifdef RR_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  // Timeout fires on the edge where the grant has lasted MAX_HOLD cycles.
  assign hit = (hold_q == HOLD_LAST);
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
  assign hit = 1'b0;
`endif

  assign win       = pick(bus.req, ptr_q);
  assign owner_req = bus.req[gnt_id_q];

  // Next-state and output decode; everything defaults to hold, tmo to 0.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    busy_d   = busy_q;
    tmo_d    = 1'b0;
    hold_d   = hold_q;
    unique case (state_q)
      IDLE: begin
        gnt_d  = 4'b0000;
        busy_d = 1'b0;
        if (|bus.req) begin
          state_d  = GRANT;
          gnt_d    = 4'b0001 << win;
          gnt_id_d = win;
          busy_d   = 1'b1;
          hold_d   = 8'd0;
        end
      end
      GRANT: begin
        if (bus.done || !owner_req || hit) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          // Rotate-left of the grant: the requester above the owner leads next.
          ptr_d   = {gnt_q[2:0], gnt_q[3]};
          // done wins over timeout; a dropped request is not a timeout either.
          tmo_d   = hit && !bus.done && owner_req;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 4'b0001;
      gnt_q    <= 4'b0000;
      gnt_id_q <= 2'd0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      hold_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      hold_q   <= hold_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;
  assign bus.tmo    = tmo_q;

endmodule

// File: tb/tb_rr_sched4.sv
// Bench for rr_sched4: directed scenarios with literal expectations, then a
// randomized run, all checked every cycle against a behavioural model.
module tb_rr_sched4;
  localparam int MH = 4;
`ifdef RR_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  rr_sched4_if bus ();

  rr_sched4 #(.MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: priority is an integer index, the owner an integer,
  // and the grant length counted in whole cycles.
  bit         m_valid = 1'b0;
  int         m_prio;
  int         m_owner;
  bit         m_busy;
  int         m_len;
  logic [3:0] e_gnt;
  logic [1:0] e_id;
  logic       e_busy;
  logic       e_tmo;

  // Compare what the last edge produced, then predict the next edge from the
  // inputs that are now stable and will be sampled there.
  always @(negedge clk) begin : model_cmp
    bit ended;
    bit timed;
    if (m_valid) begin
      chk("gnt", {28'd0, bus.gnt}, {28'd0, e_gnt});
      chk("gnt_id", {30'd0, bus.gnt_id}, {30'd0, e_id});
      chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      chk("tmo", {31'd0, bus.tmo}, {31'd0, e_tmo});
      chk("gnt_onehot0", {31'd0, $onehot0(bus.gnt)}, 32'd1);
    end
    if (rst) begin
      m_prio = 0; m_busy = 1'b0; m_len = 0; m_owner = 0;
      e_gnt = 4'd0; e_id = 2'd0; e_busy = 1'b0; e_tmo = 1'b0;
      m_valid = 1'b1;
    end else if (!m_busy) begin
      e_tmo  = 1'b0;
      e_gnt  = 4'd0;
      e_busy = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!m_busy && bus.req[(m_prio + k) % 4]) begin
          m_owner = (m_prio + k) % 4;
          m_busy  = 1'b1;
          m_len   = 1;
          e_gnt   = 4'(1 << m_owner);
          e_id    = 2'(m_owner);
          e_busy  = 1'b1;
        end
      end
    end else begin
      timed = TMO_EN && (m_len == MH);
      ended = bus.done || !bus.req[m_owner] || timed;
      if (ended) begin
        m_busy = 1'b0;
        m_prio = (m_owner + 1) % 4;
        e_gnt  = 4'd0;
        e_busy = 1'b0;
        e_tmo  = timed && !bus.done && bus.req[m_owner];
      end else begin
        m_len++;
        e_tmo = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant a single request, check it, then release with done.
  task automatic serve(input logic [3:0] r, input logic [3:0] exp, input string name);
    bus.req  = r;
    bus.done = 1'b0;
    tick();
    chk(name, {28'd0, bus.gnt}, {28'd0, exp});
    bus.done = 1'b1;
    tick();
    chk({name, "_rel"}, {28'd0, bus.gnt}, 32'd0);
    bus.done = 1'b0;
    bus.req  = 4'd0;
  endtask

  logic [3:0] rot_exp [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                              4'b0000, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    rst      = 1'b1;
    bus.req  = 4'd0;
    bus.done = 1'b0;
    repeat (2) tick();
    chk("rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_tmo", {31'd0, bus.tmo}, 32'd0);
    chk("rst_id", {30'd0, bus.gnt_id}, 32'd0);
    rst = 1'b0;

    // Rotation with all requesting and done held high.
    bus.req  = 4'b1111;
    bus.done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("rot_seq", {28'd0, bus.gnt}, {28'd0, rot_exp[i]});
    end
    bus.req  = 4'd0;
    bus.done = 1'b0;
    repeat (2) tick();

    // Single requester 2, done three cycles into the grant.
    bus.req = 4'b0100;
    tick();
    chk("single_gnt", {28'd0, bus.gnt}, 32'h4);
    chk("single_id", {30'd0, bus.gnt_id}, 32'd2);
    chk("single_busy", {31'd0, bus.busy}, 32'd1);
    repeat (2) tick();
    bus.done = 1'b1;
    tick();
    chk("single_rel", {28'd0, bus.gnt}, 32'd0);
    bus.done = 1'b0;
    bus.req  = 4'b1001;
    tick();
    chk("prio_3", {28'd0, bus.gnt}, 32'h8);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'd0;

    // Wrap and skip.
    serve(4'b0110, 4'b0010, "wrap_1");
    serve(4'b0001, 4'b0001, "skip_0");

    // Owner 1 drops its request mid-grant.
    bus.req = 4'b0010;
    tick();
    chk("drop_gnt", {28'd0, bus.gnt}, 32'h2);
    tick();
    bus.req = 4'd0;
    tick();
    chk("drop_rel", {28'd0, bus.gnt}, 32'd0);
    chk("drop_tmo", {31'd0, bus.tmo}, 32'd0);

    // Reset during a grant.
    bus.req = 4'b0100;
    tick();
    chk("mid_gnt", {28'd0, bus.gnt}, 32'h4);
    rst = 1'b1;
    tick();
    chk("mid_rst_gnt", {28'd0, bus.gnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    tick();
    chk("mid_rst_prio", {28'd0, bus.gnt}, 32'h1);
    bus.req = 4'd0;
    repeat (2) tick();

    // Long hold by requester 1.
    bus.req = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_gnt", {28'd0, bus.gnt}, 32'h2);
    end
    if (TMO_EN) begin
      tick();
      chk("tmo_rel", {28'd0, bus.gnt}, 32'd0);
      chk("tmo_pulse", {31'd0, bus.tmo}, 32'd1);
      tick();
      chk("tmo_regnt", {28'd0, bus.gnt}, 32'h2);
      chk("tmo_clear", {31'd0, bus.tmo}, 32'd0);
    end else begin
      for (int i = 0; i < 20; i++) begin
        tick();
        chk("hold_forever", {28'd0, bus.gnt}, 32'h2);
        chk("hold_tmo", {31'd0, bus.tmo}, 32'd0);
      end
    end
    bus.req = 4'd0;
    repeat (2) tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) bus.req = 4'($urandom_range(0, 15));
      bus.done = ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst      = 1'b0;
    bus.req  = 4'd0;
    bus.done = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_sched4.md
# rr_sched4

Round-robin scheduler sharing one resource among four requesters. Keeps a rotating one-hot priority pointer (a ring counter) and grants exactly one requester at a time. The grant is held until the owner signals `done` or drops its request. Sits between four client blocks and the shared datapath, driving the datapath's select/enable from `gnt`.

## Interface
- `MAX_HOLD`, 15: maximum grant length in cycles. Used only when `RR_TIMEOUT_EN` is defined. Legal range 1–255.
- `clk`  in  1  clock; all logic updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  4  request lines; bit i belongs to requester i; level-sensitive.
- `done`  in  1  owner finished; sampled only in GRANT.
- `gnt`  out  4  one-hot grant, or all zero; registered.
- `gnt_id`  out  2  binary index of the current or last owner; registered.
- `busy`  out  1  high while in GRANT; registered.
- `tmo`  out  1  one-cycle pulse when a grant is revoked by timeout; registered.

## Operation
- **Reset values** (while `rst` is sampled high):
  - state = IDLE
  - `ptr` = 4'b0001 (requester 0 has highest priority)
  - `gnt` = 0, `gnt_id` = 0, `busy` = 0, `tmo` = 0
  - hold counter = 0
  - `rst` overrides every other input, including mid-grant.
- **`ptr`**: internal one-hot priority pointer. Search order starts at the set bit and wraps 3→0.
- **State IDLE**:
  - If `req` is nonzero, select the first set bit of `req` at or after `ptr`, wrapping.
  - Next cycle: `gnt` = one-hot of the winner, `gnt_id` = its index, `busy` = 1, hold counter = 0, state = GRANT.
  - If `req` is zero, remain in IDLE with all outputs low. `gnt_id` holds its last value.
- **State GRANT**, end conditions, checked every cycle:
  - (a) `done` = 1
  - (b) `req[gnt_id]` = 0
  - (c) timeout, only when the macro is enabled
- **On any end condition**:
  - Next cycle: `gnt` = 0, `busy` = 0, state = IDLE.
  - `ptr` rotates to the bit one above the owner, with 3 wrapping to 0. This is a rotate-left of `gnt`.
- **Otherwise in GRANT**: hold counter increments, saturating at 255.
- **Dead cycle**: at least one cycle of `gnt` = 0 always separates two grants. The datapath uses it to switch muxes.
- **Simultaneous events**:
  - `done` together with new requests: release first, then the new request is arbitrated in the following IDLE cycle.
  - `done` and timeout in the same cycle: treated as `done`, and `tmo` stays 0.
- **Other `req` lines**: changes to non-owner `req` bits during GRANT are ignored.
- **Invariant**: `gnt` is always one-hot or zero. `ptr` is always one-hot.

## Timing
- **Grant latency**: `req` sampled high in IDLE at edge n gives `gnt` valid after edge n. Best case is one cycle from `req` assertion.
- **Release latency**: end condition sampled at edge m gives `gnt` low after edge m.
- **Minimum grant length**: 1 cycle, when `done` is high on the first GRANT cycle.
- **Re-grant spacing**: earliest next grant is asserted after edge m+1, so there are 2 edges between consecutive grants.
- **Timeout**: when hold counter = `MAX_HOLD`−1 in GRANT, with no `done` and `req` still high, the grant releases at that edge. `tmo` = 1 for exactly the following cycle. The grant therefore lasts exactly `MAX_HOLD` cycles.

## Configuration
- **`RR_TIMEOUT_EN` defined**:
  - Hold counter compared against `MAX_HOLD`.
  - Timeout release forced as described under Timing.
  - `tmo` active.
- **`RR_TIMEOUT_EN` undefined**:
  - No timeout; a grant lasts until `done` or the request drops.
  - `tmo` tied to 0.
  - Counter comparison logic removed.

## Test plan
- **Reset value and mid-grant reset**:
  - Stimulus: `rst` high for 2 cycles.
  - Required: `gnt`=0, `busy`=0, `tmo`=0, `gnt_id`=0, priority starts at requester 0.
  - Stimulus: assert `rst` during a grant.
  - Required: `gnt`=0 after the next edge.
- **Single requester**:
  - Stimulus: `req`=4'b0100; `done` pulses 3 cycles after grant.
  - Required: `gnt`=4'b0100, `gnt_id`=2, `busy`=1 one cycle after `req`; `gnt`=0 the cycle after `done`.
  - Required after release: requester 3 has top priority.
- **Rotation fairness**:
  - Stimulus: `req`=4'b1111 held; `done` pulsed on the first cycle of every grant.
  - Required grant sequence: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- **Wrap and skip**:
  - Stimulus: after requester 3 is served, `req`=4'b0110.
  - Required: requester 1 is granted, not 2.
  - Stimulus: then `req`=4'b0001.
  - Required: requester 0 is granted, not 2.
- **Request drop**:
  - Stimulus: owner 1 drops `req[1]` mid-grant with no `done`.
  - Required: `gnt`=0 next cycle, `tmo`=0.
- **Timeout** (`RR_TIMEOUT_EN`, `MAX_HOLD`=4):
  - Stimulus: `req`=4'b0010 held, no `done`.
  - Required: `gnt`=0010 for exactly 4 cycles, then `gnt`=0 with `tmo`=1 for one cycle.
  - Required: re-grant to requester 1 only after the dead cycle.
  - Stimulus: same with the macro undefined.
  - Required: grant held indefinitely.
